// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//  Shared types and constants for the MIPS unified-memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> XFER x4 beats -> LAST)
//   arb_owner_t : which requester owns the current transaction
//   BEATS       : byte beats per 32-bit word
//   BYTE_W      : width of one memory beat
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_LAST} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_HOST} arb_owner_t;

    localparam int BEATS  = 4;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/mips_arb_pick.sv
// ---------------------------------------------------------------------------
// mips_arb_pick
//  Two-way request picker for the memory arbiter.
//  Build option: MEM_ARB_RR_EN
//   undefined : fixed priority, CPU wins every tie
//   defined   : round-robin, a tie goes to the requester that did not own
//               the previous transaction
//  Ports
//   cpu_req_i   : CPU request
//   host_req_i  : host request
//   last_host_i : 1 when the previous grant went to the host
//   grant_o     : at least one requester is asking
//   host_sel_o  : 1 = host is chosen, 0 = CPU is chosen
//   last_host_o : updated last-owner value (new winner when grant_o=1,
//                 otherwise the incoming value)
// ---------------------------------------------------------------------------
module mips_arb_pick
    import mips_mem_pkg::*;
(
    input  logic cpu_req_i,
    input  logic host_req_i,
    input  logic last_host_i,
    output logic grant_o,
    output logic host_sel_o,
    output logic last_host_o
);

    arb_owner_t last_owner;
    arb_owner_t pick;

    assign last_owner = last_host_i ? OWN_HOST : OWN_CPU;

    always_comb begin
        pick = OWN_CPU;
        if (host_req_i && !cpu_req_i) begin
            pick = OWN_HOST;
        end else if (host_req_i && cpu_req_i) begin
`ifdef MEM_ARB_RR_EN
            pick = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
`else
            pick = OWN_CPU;
`endif
        end
    end

    assign grant_o     = cpu_req_i | host_req_i;
    assign host_sel_o  = (pick == OWN_HOST);
    assign last_host_o = grant_o ? (pick == OWN_HOST) : (last_owner == OWN_HOST);

endmodule

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//  Shares a byte-wide single-port synchronous memory between the multicycle
//  MIPS core and the host loader. Each 32-bit word access is split into four
//  little-endian byte beats (beat k moves bits [8k+7:8k]).
//  Build option: MEM_ARB_RR_EN selects round-robin tie-break (see mips_arb_pick).
//  Ports
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i: CPU word request (held until cpu_ack_o)
//   cpu_ack_o, cpu_rdata_o       : 1-cycle completion pulse, read word
//   host_*                       : same as cpu_*, host side
//   mem_addr_o/we_o/wdata_o      : memory byte address / write strobe / byte
//   mem_rdata_i                  : memory read byte, 1 cycle after address
//   busy_o, owner_o              : transaction active, owner (0 CPU, 1 host)
//  Timing: grant at edge N, beats in cycles N+1..N+4, ack in cycle N+5.
// ---------------------------------------------------------------------------
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [31:0]       cpu_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [31:0]       host_wdata_i,
    output logic              host_ack_o,
    output logic [31:0]       host_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_t              state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    arb_owner_t              owner_q, owner_d;
    arb_owner_t              last_owner_q, last_owner_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [2:0][BYTE_W-1:0]  lane_q, lane_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic [31:0]             host_rdata_q, host_rdata_d;

    logic                    grant;
    logic                    grant_host;
    logic                    last_host_next;
    logic [BYTE_W-1:0]       wbyte [BEATS];
    logic [31:0]             read_word;

    mips_arb_pick u_pick (
        .cpu_req_i   (cpu_req_i),
        .host_req_i  (host_req_i),
        .last_host_i (last_owner_q == OWN_HOST),
        .grant_o     (grant),
        .host_sel_o  (grant_host),
        .last_host_o (last_host_next)
    );

    // Byte lanes of the latched write word, indexed by beat.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbyte
        assign wbyte[gi] = wdata_q[gi*BYTE_W +: BYTE_W];
    end

    // Byte 3 arrives from memory during LAST, so the full word is
    // assembled combinationally and is valid in the ack cycle.
    assign read_word = {mem_rdata_i, lane_q[2], lane_q[1], lane_q[0]};

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            beat_q       <= 2'd0;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_HOST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            lane_q       <= '0;
            cpu_rdata_q  <= 32'd0;
            host_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lane_q       <= lane_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lane_d       = lane_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d      = ARB_XFER;
                    beat_d       = 2'd0;
                    owner_d      = grant_host ? OWN_HOST : OWN_CPU;
                    last_owner_d = last_host_next ? OWN_HOST : OWN_CPU;
                    we_d         = grant_host ? host_we_i : cpu_we_i;
                    addr_d       = (grant_host ? host_addr_i : cpu_addr_i) & ALIGN_MASK;
                    wdata_d      = grant_host ? host_wdata_i : cpu_wdata_i;
                end
            end
            ARB_XFER: begin
                // Memory data lags the address by one cycle, so beat k
                // sees the byte addressed during beat k-1.
                if (!we_q) begin
                    case (beat_q)
                        2'd1:    lane_d[0] = mem_rdata_i;
                        2'd2:    lane_d[1] = mem_rdata_i;
                        2'd3:    lane_d[2] = mem_rdata_i;
                        default: ;
                    endcase
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ARB_LAST;
                end
            end
            ARB_LAST: begin
                state_d = ARB_IDLE;
                beat_d  = 2'd0;
                if (!we_q) begin
                    if (owner_q == OWN_HOST) begin
                        host_rdata_d = read_word;
                    end else begin
                        cpu_rdata_d = read_word;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_wdata_o  = 8'd0;
        cpu_ack_o    = 1'b0;
        host_ack_o   = 1'b0;
        cpu_rdata_o  = cpu_rdata_q;
        host_rdata_o = host_rdata_q;
        busy_o       = (state_q != ARB_IDLE);
        owner_o      = busy_o && (owner_q == OWN_HOST);

        case (state_q)
            ARB_XFER: begin
                // Base is word-aligned, so OR-ing in the beat never carries.
                mem_addr_o  = addr_q | {{(ADDR_W-2){1'b0}}, beat_q};
                mem_we_o    = we_q;
                mem_wdata_o = we_q ? wbyte[beat_q] : 8'd0;
            end
            ARB_LAST: begin
                if (owner_q == OWN_HOST) begin
                    host_ack_o = 1'b1;
                    if (!we_q) host_rdata_o = read_word;
                end else begin
                    cpu_ack_o = 1'b1;
                    if (!we_q) cpu_rdata_o = read_word;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter
//  Directed bench for mips_mem_arbiter with a byte-wide synchronous memory
//  model. A vector table drives single word transactions; hand-written
//  sequences cover request changes after grant, reset mid-write and
//  simultaneous requests (expected grant order depends on MEM_ARB_RR_EN).
// ---------------------------------------------------------------------------
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cpu_req_i, cpu_we_i;
    logic [7:0]  cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_ack_o;
    logic [31:0] cpu_rdata_o;
    logic        host_req_i, host_we_i;
    logic [7:0]  host_addr_i;
    logic [31:0] host_wdata_i;
    logic        host_ack_o;
    logic [31:0] host_rdata_o;
    logic [7:0]  mem_addr_o;
    logic        mem_we_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        busy_o, owner_o;

    logic        tb_init;
    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cpu_rd  = 32'd0;
    logic [31:0] exp_host_rd = 32'd0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_ack_o    (cpu_ack_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_ack_o   (host_ack_o),
        .host_rdata_o (host_rdata_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    // Byte-wide synchronous memory: read data one cycle after address.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
            mem_rdata_i <= 8'd0;
        end else begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            mem_rdata_i <= mem[mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // One full word transaction from IDLE; called at a negedge.
    task automatic run_txn(input logic is_host, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [7:0] base,
                           input logic [31:0] exp_rd, input string tag);
        logic [31:0] wd;
        wd = wdata;
        if (is_host) begin
            host_we_i = we; host_addr_i = addr; host_wdata_i = wdata; host_req_i = 1'b1;
        end else begin
            cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_req_i = 1'b1;
        end
        @(posedge clk);   // grant edge N
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({tag, " busy"},  {31'd0, busy_o}, 32'd1);
            chk({tag, " owner"}, {31'd0, owner_o}, {31'd0, is_host});
            chk({tag, " addr"},  {24'd0, mem_addr_o}, {24'd0, base + 8'(k)});
            chk({tag, " we"},    {31'd0, mem_we_o}, {31'd0, we});
            if (we) chk({tag, " wbyte"}, {24'd0, mem_wdata_o}, (wd >> (8*k)) & 32'hFF);
            chk({tag, " early_ack"}, {30'd0, cpu_ack_o, host_ack_o}, 32'd0);
        end
        @(negedge clk);   // cycle N+5
        chk({tag, " ack"}, {30'd0, cpu_ack_o, host_ack_o}, is_host ? 32'd1 : 32'd2);
        chk({tag, " last_we"}, {31'd0, mem_we_o}, 32'd0);
        if (!we) begin
            if (is_host) exp_host_rd = exp_rd; else exp_cpu_rd = exp_rd;
        end
        chk({tag, " cpu_rdata"},  cpu_rdata_o,  exp_cpu_rd);
        chk({tag, " host_rdata"}, host_rdata_o, exp_host_rd);
        cpu_req_i = 1'b0; host_req_i = 1'b0;
        @(negedge clk);   // cycle N+6, IDLE
        chk({tag, " idle"}, {29'd0, busy_o, cpu_ack_o, host_ack_o}, 32'd0);
        chk({tag, " hold_cpu"},  cpu_rdata_o,  exp_cpu_rd);
        chk({tag, " hold_host"}, host_rdata_o, exp_host_rd);
        $display("txn %-6s %s %s addr=%h wdata=%h cpu_rdata=%h host_rdata=%h",
                 tag, is_host ? "HOST" : "CPU ", we ? "W" : "R", addr, wdata,
                 cpu_rdata_o, host_rdata_o);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        exp_cpu_rd = 32'd0;
        exp_host_rd = 32'd0;
    endtask

    typedef struct {
        logic        is_host;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  base;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] exp_own [3];
        logic [7:0] got_own [3];
        int         got_cyc [3];
        int         ngr;
        logic       prev_busy;
        logic [31:0] rst_mem;

        rst_i = 1'b1; tb_init = 1'b1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        host_req_i = 0; host_we_i = 0; host_addr_i = 0; host_wdata_i = 0;

        vecs[0] = '{1'b1, 1'b1, 8'h10, 32'h44332211, 8'h10, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 8'h10, 32'h0,        8'h10, 32'h44332211};
        vecs[2] = '{1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 8'h20, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 8'h13, 32'h0,        8'h10, 32'h44332211};
        vecs[4] = '{1'b1, 1'b0, 8'h21, 32'h0,        8'h20, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 8'hFC, 32'hCAFEF00D, 8'hFC, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 8'hFE, 32'h0,        8'hFC, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 32'h0,        8'h00, 32'h00000000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {26'd0, busy_o, owner_o, cpu_ack_o, host_ack_o, mem_we_o, 1'b0}, 32'd0);
        chk("reset_addr", {16'd0, mem_addr_o, mem_wdata_o}, 32'd0);
        chk("reset_rdata", cpu_rdata_o | host_rdata_o, 32'd0);
        rst_i = 1'b0; tb_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].is_host, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].base, vecs[i].exp_rd, $sformatf("v%0d", i));
        end

        // Request fields change and req drops after grant: original read completes.
        cpu_we_i = 1'b0; cpu_addr_i = 8'h10; cpu_req_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("chg addr0", {24'd0, mem_addr_o}, 32'h10);
        @(posedge clk); #1;
        cpu_addr_i = 8'h20; cpu_wdata_i = 32'hFFFFFFFF; cpu_we_i = 1'b1; cpu_req_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("chg addr", {24'd0, mem_addr_o}, 32'h10 + 32'(k));
            chk("chg we", {31'd0, mem_we_o}, 32'd0);
        end
        @(negedge clk);
        chk("chg ack", {30'd0, cpu_ack_o, host_ack_o}, 32'd2);
        chk("chg rdata", cpu_rdata_o, 32'h44332211);
        cpu_we_i = 1'b0;
        @(negedge clk);
        chk("chg idle", {31'd0, busy_o}, 32'd0);
        $display("txn chg    CPU  R addr=10 cpu_rdata=%h", cpu_rdata_o);

        // Reset during beat 2 of a CPU write.
        cpu_we_i = 1'b1; cpu_addr_i = 8'h30; cpu_wdata_i = 32'h12345678; cpu_req_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        @(negedge clk);
        chk("rst beat2 addr", {23'd0, mem_we_o, mem_addr_o}, 32'h132);
        @(negedge clk);
        rst_i = 1'b0;
        exp_cpu_rd = 32'd0; exp_host_rd = 32'd0;
        chk("rst idle", {29'd0, busy_o, mem_we_o, cpu_ack_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst no_ack", {30'd0, cpu_ack_o, host_ack_o}, 32'd0);
        end
        $display("txn rst    CPU  W addr=30 aborted in beat 2");
        rst_mem = 32'h00345678;
        run_txn(1'b1, 1'b0, 8'h30, 32'h0, 8'h30, rst_mem, "rstrd");

        // Both requesters held for three words.
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_own[0] = 8'd0; exp_own[1] = 8'd1; exp_own[2] = 8'd0;
`else
        exp_own[0] = 8'd0; exp_own[1] = 8'd0; exp_own[2] = 8'd0;
`endif
        cpu_we_i = 1'b0; cpu_addr_i = 8'h10; cpu_req_i = 1'b1;
        host_we_i = 1'b0; host_addr_i = 8'h20; host_req_i = 1'b1;
        ngr = 0; prev_busy = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (busy_o && !prev_busy && ngr < 3) begin
                got_own[ngr] = {7'd0, owner_o};
                got_cyc[ngr] = cyc;
                ngr++;
                if (ngr == 3) begin
                    cpu_req_i = 1'b0; host_req_i = 1'b0;
                end
            end
            if (cpu_ack_o)  chk("tie cpu_rdata",  cpu_rdata_o,  32'h44332211);
            if (host_ack_o) chk("tie host_rdata", host_rdata_o, 32'hDEADBEEF);
            prev_busy = busy_o;
            if (ngr == 3 && !busy_o) break;
        end
        cpu_req_i = 1'b0; host_req_i = 1'b0;
        chk("tie grants", ngr, 3);
        chk("tie end_idle", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < ngr; i++) begin
            chk($sformatf("tie owner%0d", i), {24'd0, got_own[i]}, {24'd0, exp_own[i]});
            if (i > 0) chk($sformatf("tie gap%0d", i), got_cyc[i] - got_cyc[i-1], 6);
            $display("txn tie%0d  grant owner=%0d cycle=%0d", i, got_own[i], got_cyc[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
